snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
// Parametrised game-flow controller for the VGA snake game. Sequences welcome, ready, play,
// pause, hit/respawn, game-over and win phases. Manages a life counter and latches difficulty
// from the switches. Generates the per-level snake move tick and the snake blink enable.
// Sits between the key/switch inputs and the snake, food and VGA-draw blocks.
// PARAMETERS
// WELCOME_CYC     150_000_000  cycles the welcome screen is held before switches are sampled
// FLASH_HALF_CYC  12_500_000   cycles per blink half-period in HIT
// FLASH_TOGGLES   6            number of snake_display toggles per HIT (even value)
// LIVES           3            lives at game start, 1..7
// WIN_SCORE       12'h100      BCD score ending the game as a win
// SPD1_CYC/SPD2_CYC/SPD3_CYC  12_500_000/6_250_000/3_125_000  move_tick period at level 1/2/3
// PORTS
// clk          in   1   25 MHz system clock
// rst_n        in   1   asynchronous, active-low reset
// key_n[3:0]   in   4   direction keys {up,down,left,right}, active-low, asynchronous to clk
// key_pause_n  in   1   pause key, active-low, asynchronous to clk
// sw_n[2:0]    in   3   difficulty switches, active-low; sw_n[2] has highest priority
// hit_wall     in   1   head hit wall (level, sampled in PLAY only)
// hit_body     in   1   head hit body (level, sampled in PLAY only)
// score_bcd    in   12  three-digit BCD score
// game_status  out  3   0 WELCOME,1 READY,2 PLAY,3 PAUSE,4 HIT,5 OVER,6 WIN
// level        out  2   latched difficulty 1..3 (0 until first latch)
// lives_left   out  3   remaining lives
// move_tick    out  1   1-cycle pulse; snake advances one cell
// snake_display out 1   snake visible
// respawn      out  1   1-cycle pulse on HIT->READY; snake block re-initialises its body
// game_reset   out  1   1-cycle pulse on OVER/WIN->WELCOME; score and food blocks clear
// BEHAVIOUR
// - Reset values: game_status=WELCOME, level=0, lives_left=LIVES, move_tick=0, snake_display=1,
//   respawn=0, game_reset=0. All counters are 0. Reset is honoured in any state, mid-flash included.
// - Keys: 2-FF sync, then a registered falling-edge detect producing a "press" pulse.
//   State changes on the 4th rising edge after the pin is first sampled low.
//   A held key yields one press only.
// - WELCOME: phase counter counts to WELCOME_CYC-1. After that, on the first cycle any sw_n is low:
//   level <= 3/2/1 for sw_n[2]/[1]/[0] (priority order), lives_left<=LIVES, go to READY.
// - READY: any direction press -> PLAY; move divider cleared on entry to PLAY.
// - PLAY: divider counts to SPDn_CYC-1 for the latched level, pulses move_tick, then wraps to 0.
//   Priority within one cycle: score_bcd>=WIN_SCORE (unsigned compare, valid BCD) -> WIN;
//   else hit_wall|hit_body -> HIT with lives_left decremented in the same edge;
//   else pause press -> PAUSE.
// - PAUSE: move_tick=0 and the divider is frozen (not cleared). Pause press -> PLAY and the
//   divider resumes. Direction presses are ignored.
// - HIT: the flash counter runs FLASH_HALF_CYC*FLASH_TOGGLES cycles.
//   snake_display inverts at every FLASH_HALF_CYC boundary and is forced to 1 on exit.
//   On exit: lives_left==0 -> OVER; otherwise -> READY with respawn pulsed.
//   Keys are ignored during the flash.
// - OVER: snake_display=0. WIN: snake_display=1.
//   In either, any direction press -> WELCOME: game_reset pulsed, all counters cleared, level kept.
// - lives_left never underflows. A hit while lives_left==0 is impossible, because OVER is
//   entered first.
// - move_tick is 0 in every state other than PLAY.
// - Illegal state encoding -> WELCOME on the next edge.
// STRUCTURE
// - Package snake_pkg: game_status encodings, level encoding, and a ceil-log2 function for
//   sizing the counters.
// - Sub-module key_press_det: 2-FF sync plus edge detect, one instance per key (5 total).
// - This module holds the FSM, the shared phase/flash counter, the move divider and the lives
//   register.
// TESTING
// Bench parameters: WELCOME_CYC=8, FLASH_HALF_CYC=4, FLASH_TOGGLES=6, LIVES=2, SPD=16/8/4.
// - sw_n=3'b101 held from reset -> READY on cycle 9, level=2; key press -> PLAY 4 cycles later,
//   move_tick every 8 cycles.
// - PLAY, hit_wall for 1 cycle -> HIT, lives_left 2->1; display toggles every 4 cycles for 24 cycles.
//   Then READY, respawn=1 for 1 cycle, snake_display=1.
// - Second hit -> lives 0; after the flash -> OVER with display=0.
//   Key press -> WELCOME with game_reset pulse.
// - PLAY, pause pressed 3 cycles after a tick, held 20 cycles, pressed again -> no ticks while paused.
//   First tick after resume lands 5 cycles after resume.
// - score_bcd=12'h100 together with hit_body in the same cycle -> WIN, lives_left unchanged.
// - rst_n asserted mid-HIT -> all outputs return to reset values asynchronously.
//   Key held low across reset -> no press detected.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game-flow controller.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package snake_pkg;

   // Encoding is visible on game_status_o and consumed by the VGA-draw block.
   typedef enum logic [2:0] {
      ST_WELCOME = 3'd0,
      ST_READY   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_HIT     = 3'd4,
      ST_OVER    = 3'd5,
      ST_WIN     = 3'd6
   } game_status_e;

   // Difficulty level; LVL_NONE only until the first switch latch.
   localparam logic [1:0] LVL_NONE = 2'd0;
   localparam logic [1:0] LVL_SLOW = 2'd1;
   localparam logic [1:0] LVL_MID  = 2'd2;
   localparam logic [1:0] LVL_FAST = 2'd3;

   // Bits needed to hold 0..value-1 (never less than 1).
   function automatic int unsigned clog2_f(input longint unsigned value);
      int unsigned width;
      width = 1;
      for (longint unsigned cap = 2; cap < value; cap = cap << 1)
         width++;
      return width;
   endfunction

endpackage

// File: rtl/key_press_det.sv
// Key press detector: 2-FF synchroniser plus registered falling-edge detect.
// Latency: press_o rises on the 3rd rising edge after the pin is first sampled low.
// Backpressure: none; a held key gives exactly one press pulse.
//
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   key_n_i  in  raw active-low key pin, asynchronous to clk
//   press_o  out one-cycle press pulse
module key_press_det (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic press_o
);

   logic sync1_q;
   logic sync2_q;
   logic last_q;
   logic press_q;

   // The chain resets to the "pressed" level so a key held down across reset
   // is only reported after it has been released and pressed again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         last_q  <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         last_q  <= sync2_q;
         press_q <= last_q & ~sync2_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the VGA snake game: phase FSM, lives, difficulty, move tick, blink.
// Latency: key effect on the 4th edge after the pin is sampled low; all outputs registered.
// Backpressure: none; presses outside the states that use them are dropped.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_n_i[3:0]               direction keys {up,down,left,right}, active-low, async
//   key_pause_n_i              pause key, active-low, async
//   sw_n_i[2:0]                difficulty switches, active-low, [2] highest priority
//   hit_wall_i, hit_body_i     collision levels, used in PLAY only
//   score_bcd_i[11:0]          three-digit BCD score
//   game_status_o[2:0]         current phase (game_status_e)
//   level_o[1:0]               latched difficulty
//   lives_left_o[2:0]          remaining lives
//   move_tick_o                one-cycle snake advance pulse
//   snake_display_o            snake visible
//   respawn_o, game_reset_o    one-cycle pulses to the snake / score+food blocks
module snake_game_ctrl #(
   parameter int unsigned WELCOME_CYC    = 150_000_000,
   parameter int unsigned FLASH_HALF_CYC = 12_500_000,
   parameter int unsigned FLASH_TOGGLES  = 6,
   parameter int unsigned LIVES          = 3,
   parameter logic [11:0] WIN_SCORE      = 12'h100,
   parameter int unsigned SPD1_CYC       = 12_500_000,
   parameter int unsigned SPD2_CYC       = 6_250_000,
   parameter int unsigned SPD3_CYC       = 3_125_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_n_i,
   input  logic        key_pause_n_i,
   input  logic [2:0]  sw_n_i,
   input  logic        hit_wall_i,
   input  logic        hit_body_i,
   input  logic [11:0] score_bcd_i,
   output logic [2:0]  game_status_o,
   output logic [1:0]  level_o,
   output logic [2:0]  lives_left_o,
   output logic        move_tick_o,
   output logic        snake_display_o,
   output logic        respawn_o,
   output logic        game_reset_o
);

   import snake_pkg::*;

   // The phase counter is shared between the welcome hold and the flash half-period.
   localparam int unsigned PH_MAX  = (WELCOME_CYC > FLASH_HALF_CYC) ? WELCOME_CYC : FLASH_HALF_CYC;
   localparam int unsigned PH_W    = clog2_f(PH_MAX);
   localparam int unsigned TG_W    = clog2_f(FLASH_TOGGLES);
   localparam int unsigned SPD_A   = (SPD1_CYC > SPD2_CYC) ? SPD1_CYC : SPD2_CYC;
   localparam int unsigned SPD_MAX = (SPD_A > SPD3_CYC) ? SPD_A : SPD3_CYC;
   localparam int unsigned DIV_W   = clog2_f(SPD_MAX);

   localparam logic [PH_W-1:0] WELCOME_LAST = PH_W'(WELCOME_CYC - 1);
   localparam logic [PH_W-1:0] HALF_LAST    = PH_W'(FLASH_HALF_CYC - 1);
   localparam logic [TG_W-1:0] TOG_LAST     = TG_W'(FLASH_TOGGLES - 1);
   localparam logic [2:0]      LIVES_INIT   = 3'(LIVES);

   logic [3:0]       dir_press_v;
   logic             dir_press;
   logic             pause_press;
   logic [1:0]       sw_level;
   logic [DIV_W-1:0] spd_last;
   logic             div_wrap;

   game_status_e     state_q;
   logic [1:0]       level_q;
   logic [2:0]       lives_q;
   logic [PH_W-1:0]  phase_q;
   logic [TG_W-1:0]  toggle_q;
   logic [DIV_W-1:0] div_q;
   logic             tick_q;
   logic             display_q;
   logic             respawn_q;
   logic             game_reset_q;

   key_press_det u_key_up    (.clk(clk), .rst_n(rst_n), .key_n_i(key_n_i[3]),   .press_o(dir_press_v[3]));
   key_press_det u_key_down  (.clk(clk), .rst_n(rst_n), .key_n_i(key_n_i[2]),   .press_o(dir_press_v[2]));
   key_press_det u_key_left  (.clk(clk), .rst_n(rst_n), .key_n_i(key_n_i[1]),   .press_o(dir_press_v[1]));
   key_press_det u_key_right (.clk(clk), .rst_n(rst_n), .key_n_i(key_n_i[0]),   .press_o(dir_press_v[0]));
   key_press_det u_key_pause (.clk(clk), .rst_n(rst_n), .key_n_i(key_pause_n_i), .press_o(pause_press));

   assign dir_press = |dir_press_v;

   // Only consulted once at least one switch is low.
   assign sw_level = !sw_n_i[2] ? LVL_FAST : (!sw_n_i[1] ? LVL_MID : LVL_SLOW);

   always_comb begin
      case (level_q)
         LVL_MID:  spd_last = DIV_W'(SPD2_CYC - 1);
         LVL_FAST: spd_last = DIV_W'(SPD3_CYC - 1);
         default:  spd_last = DIV_W'(SPD1_CYC - 1);
      endcase
   end

   assign div_wrap = (div_q == spd_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WELCOME;
         level_q      <= LVL_NONE;
         lives_q      <= LIVES_INIT;
         phase_q      <= '0;
         toggle_q     <= '0;
         div_q        <= '0;
         tick_q       <= 1'b0;
         display_q    <= 1'b1;
         respawn_q    <= 1'b0;
         game_reset_q <= 1'b0;
      end else begin
         tick_q       <= 1'b0;
         respawn_q    <= 1'b0;
         game_reset_q <= 1'b0;
         case (state_q)
            ST_WELCOME: begin
               if (phase_q != WELCOME_LAST) begin
                  phase_q <= phase_q + 1'b1;
               end else if (sw_n_i != 3'b111) begin
                  level_q <= sw_level;
                  lives_q <= LIVES_INIT;
                  phase_q <= '0;
                  state_q <= ST_READY;
               end
            end
            ST_READY: begin
               if (dir_press) begin
                  div_q   <= '0;
                  state_q <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               // The divider advances on every PLAY cycle, including the one that
               // leaves for PAUSE, so a resumed game keeps its position in the period.
               div_q <= div_wrap ? '0 : div_q + 1'b1;
               if (score_bcd_i >= WIN_SCORE) begin
                  display_q <= 1'b1;
                  state_q   <= ST_WIN;
               end else if (hit_wall_i | hit_body_i) begin
                  if (lives_q != 3'd0)
                     lives_q <= lives_q - 3'd1;
                  phase_q  <= '0;
                  toggle_q <= '0;
                  state_q  <= ST_HIT;
               end else if (pause_press) begin
                  state_q <= ST_PAUSE;
               end else begin
                  tick_q <= div_wrap;
               end
            end
            ST_PAUSE: begin
               if (pause_press)
                  state_q <= ST_PLAY;
            end
            ST_HIT: begin
               if (phase_q == HALF_LAST) begin
                  phase_q <= '0;
                  if (toggle_q == TOG_LAST) begin
                     // Last half-period boundary ends the flash instead of toggling.
                     toggle_q <= '0;
                     if (lives_q == 3'd0) begin
                        display_q <= 1'b0;
                        state_q   <= ST_OVER;
                     end else begin
                        display_q <= 1'b1;
                        respawn_q <= 1'b1;
                        state_q   <= ST_READY;
                     end
                  end else begin
                     toggle_q  <= toggle_q + 1'b1;
                     display_q <= ~display_q;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_OVER, ST_WIN: begin
               if (dir_press) begin
                  game_reset_q <= 1'b1;
                  phase_q      <= '0;
                  toggle_q     <= '0;
                  div_q        <= '0;
                  display_q    <= 1'b1;
                  state_q      <= ST_WELCOME;
               end
            end
            default: state_q <= ST_WELCOME;
         endcase
      end
   end

   assign game_status_o   = state_q;
   assign level_o         = level_q;
   assign lives_left_o    = lives_q;
   assign move_tick_o     = tick_q;
   assign snake_display_o = display_q;
   assign respawn_o       = respawn_q;
   assign game_reset_o    = game_reset_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

   localparam logic [2:0] S_WELCOME = 3'd0;
   localparam logic [2:0] S_READY   = 3'd1;
   localparam logic [2:0] S_PLAY    = 3'd2;
   localparam logic [2:0] S_PAUSE   = 3'd3;
   localparam logic [2:0] S_HIT     = 3'd4;
   localparam logic [2:0] S_OVER    = 3'd5;
   localparam logic [2:0] S_WIN     = 3'd6;

   // {status, level, lives, move_tick, snake_display, respawn, game_reset}
   localparam logic [11:0] RESET_VEC = {3'd0, 2'd0, 3'd2, 4'b0100};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key_n;
   logic        key_pause_n;
   logic [2:0]  sw_n;
   logic        hit_wall;
   logic        hit_body;
   logic [11:0] score_bcd;
   logic [2:0]  game_status;
   logic [1:0]  level;
   logic [2:0]  lives_left;
   logic        move_tick;
   logic        snake_display;
   logic        respawn;
   logic        game_reset;
   logic [11:0] obs_all;

   int checks = 0;
   int errors = 0;

   snake_game_ctrl #(
      .WELCOME_CYC(8), .FLASH_HALF_CYC(4), .FLASH_TOGGLES(6), .LIVES(2),
      .WIN_SCORE(12'h100), .SPD1_CYC(16), .SPD2_CYC(8), .SPD3_CYC(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_n_i(key_n), .key_pause_n_i(key_pause_n),
      .sw_n_i(sw_n), .hit_wall_i(hit_wall), .hit_body_i(hit_body), .score_bcd_i(score_bcd),
      .game_status_o(game_status), .level_o(level), .lives_left_o(lives_left),
      .move_tick_o(move_tick), .snake_display_o(snake_display), .respawn_o(respawn),
      .game_reset_o(game_reset)
   );

   assign obs_all = {game_status, level, lives_left, move_tick, snake_display, respawn, game_reset};

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; key_n = 4'hF; key_pause_n = 1'b1; sw_n = 3'b101;
      hit_wall = 1'b0; hit_body = 1'b0; score_bcd = 12'h000;
      step(3);
      checks++;
      if (obs_all !== RESET_VEC) begin
         errors++; $display("FAIL reset_outputs got=%h exp=%h", obs_all, RESET_VEC);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_welcome;
      step(7);
      checks++;
      if (game_status !== S_WELCOME) begin
         errors++; $display("FAIL welcome_hold status got=%0d exp=%0d", game_status, S_WELCOME);
      end
      step(1);
      checks++;
      if ({game_status, level, lives_left} !== {S_READY, 2'd2, 3'd2}) begin
         errors++; $display("FAIL welcome_to_ready st/lvl/lives got=%0d/%0d/%0d exp=1/2/2",
                            game_status, level, lives_left);
      end
   endtask

   task automatic test_play_ticks;
      key_n[3] = 1'b0;
      step(3);
      checks++;
      if (game_status !== S_READY) begin
         errors++; $display("FAIL press_latency_early status got=%0d exp=%0d", game_status, S_READY);
      end
      step(1);
      checks++;
      if (game_status !== S_PLAY) begin
         errors++; $display("FAIL press_to_play status got=%0d exp=%0d", game_status, S_PLAY);
      end
      key_n = 4'hF;
      for (int k = 1; k <= 16; k++) begin
         step(1);
         checks++;
         if (move_tick !== ((k % 8) == 0)) begin
            errors++; $display("FAIL tick_period k=%0d got=%b exp=%b", k, move_tick, (k % 8) == 0);
         end
      end
   endtask

   task automatic test_hit_respawn;
      logic exp_disp;
      hit_wall = 1'b1;
      step(1);
      hit_wall = 1'b0;
      checks++;
      if ({game_status, lives_left, snake_display, move_tick} !== {S_HIT, 3'd1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL hit_entry st/lives/disp/tick got=%0d/%0d/%b/%b exp=4/1/1/0",
                            game_status, lives_left, snake_display, move_tick);
      end
      for (int j = 1; j <= 25; j++) begin
         if (j == 5)  key_n[1] = 1'b0;
         if (j == 10) key_n = 4'hF;
         step(1);
         exp_disp = (j >= 24) ? 1'b1 : (((j / 4) % 2) == 0);
         checks++;
         if ({game_status, snake_display, respawn} !== {(j < 24) ? S_HIT : S_READY, exp_disp, j == 24}) begin
            errors++; $display("FAIL hit_flash j=%0d st/disp/resp got=%0d/%b/%b exp=%0d/%b/%b", j,
                               game_status, snake_display, respawn, (j < 24) ? S_HIT : S_READY,
                               exp_disp, j == 24);
         end
      end
   endtask

   task automatic test_over;
      key_n[2] = 1'b0;
      step(4);
      key_n = 4'hF;
      checks++;
      if (game_status !== S_PLAY) begin
         errors++; $display("FAIL replay status got=%0d exp=%0d", game_status, S_PLAY);
      end
      hit_body = 1'b1;
      step(1);
      hit_body = 1'b0;
      checks++;
      if ({game_status, lives_left} !== {S_HIT, 3'd0}) begin
         errors++; $display("FAIL last_hit st/lives got=%0d/%0d exp=4/0", game_status, lives_left);
      end
      step(24);
      checks++;
      if ({game_status, snake_display, respawn} !== {S_OVER, 1'b0, 1'b0}) begin
         errors++; $display("FAIL over_entry st/disp/resp got=%0d/%b/%b exp=5/0/0",
                            game_status, snake_display, respawn);
      end
      key_n[0] = 1'b0;
      step(4);
      checks++;
      if ({game_status, game_reset, level} !== {S_WELCOME, 1'b1, 2'd2}) begin
         errors++; $display("FAIL over_exit st/greset/lvl got=%0d/%b/%0d exp=0/1/2",
                            game_status, game_reset, level);
      end
      step(1);
      key_n = 4'hF;
      checks++;
      if (game_reset !== 1'b0) begin
         errors++; $display("FAIL game_reset_width got=%b exp=0", game_reset);
      end
   endtask

   task automatic test_pause;
      step(6);
      checks++;
      if (game_status !== S_WELCOME) begin
         errors++; $display("FAIL rewelcome_hold status got=%0d exp=%0d", game_status, S_WELCOME);
      end
      step(1);
      checks++;
      if ({game_status, lives_left} !== {S_READY, 3'd2}) begin
         errors++; $display("FAIL rewelcome_ready st/lives got=%0d/%0d exp=1/2", game_status, lives_left);
      end
      key_n[3] = 1'b0;
      step(4);
      key_n = 4'hF;
      step(8);
      checks++;
      if (move_tick !== 1'b1) begin
         errors++; $display("FAIL pause_pre_tick got=%b exp=1", move_tick);
      end
      step(7);
      key_pause_n = 1'b0;
      step(1);
      checks++;
      if (move_tick !== 1'b1) begin
         errors++; $display("FAIL pause_ref_tick got=%b exp=1", move_tick);
      end
      step(2);
      checks++;
      if (game_status !== S_PLAY) begin
         errors++; $display("FAIL pause_latency status got=%0d exp=%0d", game_status, S_PLAY);
      end
      step(1);
      checks++;
      if ({game_status, move_tick} !== {S_PAUSE, 1'b0}) begin
         errors++; $display("FAIL pause_entry st/tick got=%0d/%b exp=3/0", game_status, move_tick);
      end
      for (int k = 1; k <= 20; k++) begin
         if (k == 5) key_n[2] = 1'b0;
         if (k == 8) key_n = 4'hF;
         step(1);
         checks++;
         if ({game_status, move_tick} !== {S_PAUSE, 1'b0}) begin
            errors++; $display("FAIL paused k=%0d st/tick got=%0d/%b exp=3/0", k, game_status, move_tick);
         end
      end
      key_pause_n = 1'b1;
      step(3);
      key_pause_n = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step(1);
         checks++;
         if ({game_status, move_tick} !== {(k < 4) ? S_PAUSE : S_PLAY, k == 9}) begin
            errors++; $display("FAIL resume k=%0d st/tick got=%0d/%b exp=%0d/%b", k, game_status,
                               move_tick, (k < 4) ? S_PAUSE : S_PLAY, k == 9);
         end
      end
      key_pause_n = 1'b1;
   endtask

   task automatic test_win;
      score_bcd = 12'h099;
      step(1);
      checks++;
      if (game_status !== S_PLAY) begin
         errors++; $display("FAIL score_below_win status got=%0d exp=%0d", game_status, S_PLAY);
      end
      score_bcd = 12'h100;
      hit_body = 1'b1;
      step(1);
      score_bcd = 12'h000;
      hit_body = 1'b0;
      checks++;
      if ({game_status, lives_left, snake_display, move_tick} !== {S_WIN, 3'd2, 1'b1, 1'b0}) begin
         errors++; $display("FAIL win_over_hit st/lives/disp/tick got=%0d/%0d/%b/%b exp=6/2/1/0",
                            game_status, lives_left, snake_display, move_tick);
      end
      key_n[1] = 1'b0;
      step(4);
      key_n = 4'hF;
      checks++;
      if ({game_status, game_reset} !== {S_WELCOME, 1'b1}) begin
         errors++; $display("FAIL win_exit st/greset got=%0d/%b exp=0/1", game_status, game_reset);
      end
   endtask

   task automatic test_reset_mid_hit;
      step(8);
      key_n[3] = 1'b0;
      step(4);
      key_n = 4'hF;
      checks++;
      if (game_status !== S_PLAY) begin
         errors++; $display("FAIL third_play status got=%0d exp=%0d", game_status, S_PLAY);
      end
      hit_wall = 1'b1;
      step(1);
      hit_wall = 1'b0;
      step(5);
      checks++;
      if ({game_status, lives_left, snake_display} !== {S_HIT, 3'd1, 1'b0}) begin
         errors++; $display("FAIL mid_flash st/lives/disp got=%0d/%0d/%b exp=4/1/0",
                            game_status, lives_left, snake_display);
      end
      key_n[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_all !== RESET_VEC) begin
         errors++; $display("FAIL async_reset got=%h exp=%h", obs_all, RESET_VEC);
      end
      step(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         checks++;
         if (dut.u_key_right.press_o !== 1'b0) begin
            errors++; $display("FAIL held_key_press k=%0d got=%b exp=0", k, dut.u_key_right.press_o);
         end
      end
      checks++;
      if (game_status !== S_READY) begin
         errors++; $display("FAIL held_key_state status got=%0d exp=%0d", game_status, S_READY);
      end
      key_n = 4'hF;
      step(2);
   endtask

   initial begin
      test_reset();
      test_welcome();
      test_play_ticks();
      test_hit_respawn();
      test_over();
      test_pause();
      test_win();
      test_reset_mid_hit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
